// File: rtl/data_mem_dma_if.sv
// Command and memory-port bundle for the data_mem_dma block-transfer engine.
// master: the engine (drives status and memory port); slave: CPU side and data_mem.
interface data_mem_dma_if #(
    parameter int WIDTH = 8
) ();
    logic             START;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] SRC;
    logic [WIDTH-1:0] DST;
    logic [WIDTH-1:0] LEN;
    logic [WIDTH-1:0] FILL_VAL;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;
    logic             MEM_EN;
    logic             MEM_WR;
    logic [WIDTH-1:0] MEM_ADDR;
    logic [WIDTH-1:0] MEM_WDATA;
    logic [WIDTH-1:0] MEM_RDATA;

    modport master (
        input  START, MODE, SRC, DST, LEN, FILL_VAL, MEM_RDATA,
        output BUSY, DONE, RESULT, MEM_EN, MEM_WR, MEM_ADDR, MEM_WDATA
    );

    modport slave (
        output START, MODE, SRC, DST, LEN, FILL_VAL, MEM_RDATA,
        input  BUSY, DONE, RESULT, MEM_EN, MEM_WR, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/data_mem_dma.sv
// FILL / COPY / CHECKSUM engine driving the single-port data_mem.
// Ports: CLK, RST_N (sync, active-low), bus (command, status and memory port).
module data_mem_dma #(
    parameter int WIDTH = 8
) (
    input logic           CLK,
    input logic           RST_N,
    data_mem_dma_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FILL_WR, S_CP_RD, S_CP_CAP,
        S_CP_WR, S_SUM_RD, S_SUM_ACC, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] fill_q, fill_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             en_q, en_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             last;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        fill_d   = fill_q;
        buf_d    = buf_q;
        result_d = result_q;
        last     = (k_q == len_q - WIDTH'(1));

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    src_d    = bus.SRC;
                    dst_d    = bus.DST;
                    len_d    = bus.LEN;
                    fill_d   = bus.FILL_VAL;
                    k_d      = '0;
                    result_d = '0;
                    if (bus.LEN == '0 || bus.MODE == 2'b11) begin
                        state_d = S_DONE;
                    end else if (bus.MODE == 2'b00) begin
                        state_d = S_FILL_WR;
                    end else if (bus.MODE == 2'b01) begin
                        state_d = S_CP_RD;
                    end else begin
                        state_d = S_SUM_RD;
                    end
                end
            end
            S_FILL_WR: begin
                if (last) state_d = S_DONE;
                else      k_d = k_q + WIDTH'(1);
            end
            S_CP_RD:  state_d = S_CP_CAP;
            S_CP_CAP: begin
                buf_d   = bus.MEM_RDATA;
                state_d = S_CP_WR;
            end
            S_CP_WR: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + WIDTH'(1);
                    state_d = S_CP_RD;
                end
            end
            S_SUM_RD: state_d = S_SUM_ACC;
            S_SUM_ACC: begin
                result_d = result_q + bus.MEM_RDATA;
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + WIDTH'(1);
                    state_d = S_SUM_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port is registered: decode from the state being entered
    // so each access is presented during its own state's cycle.
    always_comb begin
        en_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_d)
            S_FILL_WR: begin
                en_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = dst_d + k_d;
                wdata_d = fill_d;
            end
            S_CP_RD: begin
                en_d   = 1'b1;
                addr_d = src_d + k_d;
            end
            S_CP_WR: begin
                en_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = dst_d + k_d;
                wdata_d = buf_d;
            end
            S_SUM_RD: begin
                en_d   = 1'b1;
                addr_d = src_d + k_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            fill_q   <= '0;
            buf_q    <= '0;
            result_q <= '0;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            fill_q   <= fill_d;
            buf_q    <= buf_d;
            result_q <= result_d;
            en_q     <= en_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.DONE      = (state_q == S_DONE);
    assign bus.RESULT    = result_q;
    assign bus.MEM_EN    = en_q;
    assign bus.MEM_WR    = wr_q;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
endmodule

// File: tb/tb_data_mem_dma.sv
// Self-checking bench for data_mem_dma with a behavioural data_mem.
// Memory accesses are checked cycle-exactly against a scoreboard queue.
module tb_data_mem_dma;
    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    acc_t       sbq[$];
    logic [7:0] mem [256];
    logic [7:0] model [256];
    logic [7:0] rdata_q = 8'h00;
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = 8'h00;
    logic [7:0] pre_data = 8'h00;

    data_mem_dma_if #(.WIDTH(8)) b ();

    data_mem_dma #(.WIDTH(8)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (b.MEM_EN === 1'b1) begin
            if (b.MEM_WR) mem[b.MEM_ADDR] <= b.MEM_WDATA;
            else          rdata_q <= mem[b.MEM_ADDR];
        end
    end

    assign b.MEM_RDATA = rdata_q;

    always @(negedge clk) begin
        acc_t       e;
        logic [7:0] od;
        if (b.MEM_EN === 1'b1) begin
            vectors++;
            assert (sbq.size() != 0) else begin
                miscompares++;
                $error("FAIL access_unexpected: observed wr=%0d addr=%h cyc=%0d, expected no access",
                       b.MEM_WR, b.MEM_ADDR, cyc);
            end
            if (sbq.size() != 0) begin
                e  = sbq.pop_front();
                od = b.MEM_WR ? b.MEM_WDATA : 8'h00;
                assert ({b.MEM_WR, b.MEM_ADDR, od, cyc} === {e.wr, e.addr, e.data, e.cyc})
                else begin
                    miscompares++;
                    $error("FAIL access: observed wr=%0d addr=%h data=%h cyc=%0d expected wr=%0d addr=%h data=%h cyc=%0d",
                           b.MEM_WR, b.MEM_ADDR, od, cyc, e.wr, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit wr, input logic [7:0] a, input logic [7:0] d, input int c);
        acc_t e;
        e.wr = wr; e.addr = a; e.data = d; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        model[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive(input logic [1:0] mode, input logic [7:0] src, input logic [7:0] dst,
                         input logic [7:0] len, input logic [7:0] fill);
        b.MODE = mode; b.SRC = src; b.DST = dst; b.LEN = len; b.FILL_VAL = fill;
    endtask

    task automatic run(input logic [1:0] mode, input logic [7:0] src, input logic [7:0] dst,
                       input logic [7:0] len, input logic [7:0] fill,
                       input string tag, input bit pulse);
        int         s, n, explat;
        logic [7:0] sum, a, d;
        bit         empty;
        empty = (len == 8'h00) || (mode == 2'b11);
        @(negedge clk);
        s = cyc; sum = 8'h00;
        for (int k = 0; k < int'(len); k++) begin
            case (mode)
                2'b00: begin
                    a = dst + 8'(k);
                    push(1'b1, a, fill, s + 1 + k);
                    model[a] = fill;
                end
                2'b01: begin
                    d = model[src + 8'(k)];
                    push(1'b0, src + 8'(k), 8'h00, s + 1 + 3 * k);
                    push(1'b1, dst + 8'(k), d, s + 3 + 3 * k);
                    model[dst + 8'(k)] = d;
                end
                2'b10: begin
                    push(1'b0, src + 8'(k), 8'h00, s + 1 + 2 * k);
                    sum = sum + model[src + 8'(k)];
                end
                default: ;
            endcase
        end
        explat = empty ? 1 : (mode == 2'b00) ? int'(len) + 1 :
                 (mode == 2'b01) ? 3 * int'(len) + 1 : 2 * int'(len) + 1;
        drive(mode, src, dst, len, fill);
        b.START = 1'b1;
        @(negedge clk);
        b.START = 1'b0;
        if (!empty) chk({tag, "_busy"}, 32'(b.BUSY), 32'd1);
        if (pulse) begin
            @(negedge clk);
            drive(2'b00, 8'h00, 8'h80, 8'h02, 8'h55);
            b.START = 1'b1;
            @(negedge clk);
            b.START = 1'b0;
        end
        n = 0;
        while (b.DONE !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(cyc - s), 32'(explat));
        chk({tag, "_busy_in_done"}, 32'(b.BUSY), 32'd0);
        if (mode == 2'b10 || empty) chk({tag, "_result"}, 32'(b.RESULT), 32'(sum));
    endtask

    initial begin
        int s;
        b.START = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(b.BUSY),      32'd0);
        chk("rst_done",  32'(b.DONE),      32'd0);
        chk("rst_en",    32'(b.MEM_EN),    32'd0);
        chk("rst_wr",    32'(b.MEM_WR),    32'd0);
        chk("rst_addr",  32'(b.MEM_ADDR),  32'd0);
        chk("rst_wdata", 32'(b.MEM_WDATA), 32'd0);
        chk("rst_result", 32'(b.RESULT),   32'd0);
        rst_n = 1'b1;

        poke(8'h14, 8'h5A);
        run(2'b00, 8'h00, 8'h10, 8'h04, 8'hA5, "fill", 1'b0);
        for (int i = 0; i < 4; i++) chk("fill_rb", 32'(mem[8'h10 + 8'(i)]), 32'h0000_00A5);
        chk("fill_rb_14", 32'(mem[8'h14]), 32'h0000_005A);

        poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03);
        run(2'b01, 8'h20, 8'h40, 8'h03, 8'h00, "copy", 1'b0);
        for (int i = 0; i < 3; i++) chk("copy_rb", 32'(mem[8'h40 + 8'(i)]), 32'(i + 1));

        poke(8'h30, 8'h80); poke(8'h31, 8'h90); poke(8'h32, 8'h10); poke(8'h33, 8'h01);
        run(2'b10, 8'h30, 8'h00, 8'h04, 8'h00, "sum", 1'b1);
        chk("sum_value", 32'(b.RESULT), 32'h0000_0021);
        drive(2'b00, 8'h00, 8'h90, 8'h01, 8'h77);
        b.START = 1'b1;
        @(negedge clk);
        b.START = 1'b0;
        chk("done_start_busy", 32'(b.BUSY), 32'd0);
        chk("done_start_done", 32'(b.DONE), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_start_idle", 32'(b.BUSY), 32'd0);
        chk("result_hold", 32'(b.RESULT), 32'h0000_0021);

        run(2'b11, 8'h30, 8'h60, 8'h05, 8'h11, "mode11", 1'b0);
        run(2'b00, 8'h00, 8'h60, 8'h00, 8'h11, "fill_len0", 1'b0);
        run(2'b10, 8'h30, 8'h00, 8'h00, 8'h00, "sum_len0", 1'b0);

        run(2'b00, 8'h00, 8'hFE, 8'h04, 8'h3C, "wrap", 1'b0);
        chk("wrap_fe", 32'(mem[8'hFE]), 32'h0000_003C);
        chk("wrap_ff", 32'(mem[8'hFF]), 32'h0000_003C);
        chk("wrap_00", 32'(mem[8'h00]), 32'h0000_003C);
        chk("wrap_01", 32'(mem[8'h01]), 32'h0000_003C);

        poke(8'h50, 8'hEE); poke(8'h51, 8'hEE);
        @(negedge clk);
        s = cyc;
        push(1'b0, 8'h20, 8'h00, s + 1);
        push(1'b1, 8'h50, 8'h01, s + 3);
        push(1'b0, 8'h21, 8'h00, s + 4);
        drive(2'b01, 8'h20, 8'h50, 8'h03, 8'h00);
        b.START = 1'b1;
        @(negedge clk);
        b.START = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(b.BUSY),   32'd0);
        chk("abort_en",   32'(b.MEM_EN), 32'd0);
        chk("abort_done", 32'(b.DONE),   32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(b.DONE), 32'd0);
        end
        chk("abort_el1", 32'(mem[8'h50]), 32'h0000_0001);
        chk("abort_el2", 32'(mem[8'h51]), 32'h0000_00EE);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
